// File: rtl/ascii_msg_pkg.sv
// Shared types and constant message ROM for the ASCII message streamer.
// Holds the FSM state enum, ROM image and per-message start addresses.
package ascii_msg_pkg;

  localparam int BYTE_W     = 8;
  localparam int ROM_MSGS   = 4;
  localparam int ROM_BYTES  = 64;
  localparam int ROM_ADDR_W = $clog2(ROM_BYTES);

  localparam logic [BYTE_W-1:0] ASCII_NUL = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PACE,
    PRESENT,
    CSUM,
    DONE
  } state_t;

  // Messages packed back to back, each NUL-terminated, tail zero-filled.
  localparam logic [0:ROM_BYTES-1][BYTE_W-1:0] ROM = {
    "Tajumulco", ASCII_NUL,
    "Tacana",    ASCII_NUL,
    "Fuego",     ASCII_NUL,
    ASCII_NUL,
    {40{ASCII_NUL}}
  };

  localparam logic [0:ROM_MSGS-1][ROM_ADDR_W-1:0] MSG_BASE = {
    6'd0, 6'd10, 6'd17, 6'd23
  };

endpackage

// File: rtl/ascii_msg_streamer_msg_rom.sv
// Synchronous-read constant message ROM, one cycle read latency.
// Contents come from ascii_msg_pkg::ROM.
module msg_rom
  import ascii_msg_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = BYTE_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Registered read of the addressed byte.
  always_ff @(posedge clk) begin
    data <= DATA_W'(ROM[addr]);
  end

endmodule

// File: rtl/ascii_msg_streamer.sv
// Multi-message ASCII streamer over a valid/ready byte stream with pacing.
// Optional MSG_CHECKSUM_EN appends an XOR checksum byte to one-shot messages.
module ascii_msg_streamer
  import ascii_msg_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MSG_COUNT = ROM_MSGS,
  parameter int ROM_DEPTH = ROM_BYTES,
  parameter int PACE_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MSG_COUNT)-1:0] msg_sel,
  input  logic                         loop_en,
  input  logic [PACE_W-1:0]            pace_div,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int ADDR_W = $clog2(ROM_DEPTH);

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] base;
  logic [PACE_W-1:0] pace_q;
  logic [PACE_W-1:0] cnt;
  logic [DATA_W-1:0] rom_q;
  logic              sel_ok;
  logic              is_nul;
  logic              pace_hit;
`ifdef MSG_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
`endif

  assign sel_ok   = 32'(msg_sel) < MSG_COUNT;
  assign is_nul   = rom_q == DATA_W'(ASCII_NUL);
  assign pace_hit = cnt == pace_q;

  msg_rom #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rom (
    .clk (clk),
    .addr(addr),
    .data(rom_q)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and status outputs; rom_q is valid while in PACE.
  always_comb begin
    state_nx  = state;
    busy      = state != IDLE;
    out_valid = (state == PRESENT) || (state == CSUM);
    done      = state == DONE;
    unique case (state)
      IDLE:
        if (start && sel_ok) state_nx = FETCH;
      FETCH:
        state_nx = PACE;
      PACE:
        if (is_nul) begin
          if (loop_en) begin
            state_nx = FETCH;
          end else begin
`ifdef MSG_CHECKSUM_EN
            if (pace_hit) state_nx = CSUM;
`else
            state_nx = DONE;
`endif
          end
        end else if (pace_hit) begin
          state_nx = PRESENT;
        end
      PRESENT:
        if (out_ready) state_nx = FETCH;
      CSUM:
        if (out_ready) state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Address, pace counter, output byte and checksum datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      base     <= '0;
      pace_q   <= '0;
      cnt      <= '0;
      out_data <= '0;
`ifdef MSG_CHECKSUM_EN
      acc      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (start && sel_ok) begin
            base   <= ADDR_W'(MSG_BASE[msg_sel]);
            addr   <= ADDR_W'(MSG_BASE[msg_sel]);
            pace_q <= pace_div;
`ifdef MSG_CHECKSUM_EN
            acc    <= '0;
`endif
          end
        end
        PACE: begin
          cnt <= cnt + PACE_W'(1);
          if (is_nul && loop_en) begin
            addr <= base;
            cnt  <= '0;
`ifdef MSG_CHECKSUM_EN
            acc  <= '0;
`endif
          end else if (pace_hit) begin
            cnt <= '0;
`ifdef MSG_CHECKSUM_EN
            out_data <= is_nul ? acc : rom_q;
`else
            if (!is_nul) out_data <= rom_q;
`endif
          end
        end
        PRESENT: begin
          cnt <= '0;
          if (out_ready) begin
            addr <= addr + ADDR_W'(1);
`ifdef MSG_CHECKSUM_EN
            acc  <= acc ^ out_data;
`endif
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_msg_streamer.sv
// Directed self-checking bench for ascii_msg_streamer.
// Table-driven one-shot runs plus loop, empty-loop and reset sequences.
module tb_ascii_msg_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  msg_sel;
  logic        loop_en;
  logic [15:0] pace_div;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ascii_msg_streamer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .msg_sel  (msg_sel),
    .loop_en  (loop_en),
    .pace_div (pace_div),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] sel;
    int         pace;
    string      txt;
    logic [7:0] cs;
    bit         rnd;
    bit         spam;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input vec_t v);
    logic [7:0] q[$];
    int n, t0, t_hs, dn, t_dn;
    bit first, pv, hs_prev;
    logic [7:0] pd;
    n = 0; dn = 0; t_dn = 0; t_hs = 0;
    first = 1; pv = 0; hs_prev = 0; pd = '0;
    for (int i = 0; i < v.txt.len(); i++) q.push_back(v.txt[i]);
`ifdef MSG_CHECKSUM_EN
    q.push_back(v.cs);
`endif
    msg_sel  = v.sel;
    pace_div = 16'(v.pace);
    start    = 1'b1;
    step();
    t0 = cyc;
    start = v.spam;
    if (v.spam) begin
      msg_sel  = ~v.sel;
      pace_div = 16'd9;
    end
    for (int k = 0; k < 600; k++) begin
      out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        dn++;
        t_dn = cyc;
        break;
      end
      if (pv && !hs_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
      end
      if (out_valid) begin
        if (first) begin
          chk("first_latency", cyc - t0, 2 + v.pace);
          first = 0;
        end else if (!pv) begin
          chk("byte_gap", cyc - t_hs, 2 + v.pace);
        end
        if (out_ready) begin
          if (n < q.size()) chk("byte", out_data, q[n]);
          n++;
          t_hs = cyc + 1;
        end
      end
      hs_prev = out_valid && out_ready;
      pv = out_valid;
      pd = out_data;
      step();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("byte_count", n, q.size());
    chk("done_seen", dn, 1);
`ifndef MSG_CHECKSUM_EN
    if (v.txt.len() == 0) chk("empty_done_latency", t_dn - t0, 2);
`endif
    step();
    chk("idle_busy", busy, 0);
    chk("done_once", done, 0);
  endtask

  vec_t tbl[5];

  initial begin
    string      exp_l;
    int         n, dn, vc, total;
    logic [7:0] eb;

    tbl[0] = '{sel: 2'd2, pace: 0, txt: "Fuego",     cs: 8'h5E, rnd: 0, spam: 1};
    tbl[1] = '{sel: 2'd1, pace: 4, txt: "Tacana",    cs: 8'h38, rnd: 1, spam: 0};
    tbl[2] = '{sel: 2'd0, pace: 1, txt: "Tajumulco", cs: 8'h52, rnd: 0, spam: 0};
    tbl[3] = '{sel: 2'd3, pace: 0, txt: "",          cs: 8'h00, rnd: 0, spam: 1};
    tbl[4] = '{sel: 2'd1, pace: 0, txt: "Tacana",    cs: 8'h38, rnd: 1, spam: 0};

    rst = 1'b1; start = 1'b0; loop_en = 1'b0; out_ready = 1'b1;
    msg_sel = '0; pace_div = '0;
    step(); step();
    chk("rst_outs", {out_valid, busy, done, out_data}, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("idle_outs", {out_valid, busy, done}, 0);
    end

    for (int i = 0; i < 5; i++) run_msg(tbl[i]);

    // Loop mode: "Fuego" repeats; drop loop_en during third pass.
    exp_l = "FuegoFuegoFuego";
    total = 15;
`ifdef MSG_CHECKSUM_EN
    total = 16;
`endif
    loop_en = 1'b1; msg_sel = 2'd2; pace_div = '0; start = 1'b1;
    step();
    start = 1'b0;
    n = 0; dn = 0;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        chk("loop_done_at", n, total);
        dn++;
        break;
      end
      if (out_valid) begin
        eb = (n < 15) ? exp_l[n] : 8'h5E;
        chk("loop_byte", out_data, eb);
        n++;
        if (n == 12) loop_en = 1'b0;
      end
      step();
    end
    chk("loop_done_seen", dn, 1);
    step();

    // Empty message in loop mode spins with no output until loop_en drops.
    loop_en = 1'b1; msg_sel = 2'd3; start = 1'b1;
    step();
    start = 1'b0;
    vc = 0; dn = 0;
    for (int k = 0; k < 20; k++) begin
      vc += int'(out_valid);
      dn += int'(done);
      step();
    end
    chk("empty_loop_valid", vc, 0);
    chk("empty_loop_done", dn, 0);
    chk("empty_loop_busy", busy, 1);
    loop_en = 1'b0;
    vc = 0; dn = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) begin
        dn++;
        break;
      end
      vc += int'(out_valid);
      step();
    end
`ifdef MSG_CHECKSUM_EN
    chk("empty_exit_bytes", vc, 1);
`else
    chk("empty_exit_bytes", vc, 0);
`endif
    chk("empty_exit_done", dn, 1);
    step();

    // Reset mid-stream returns everything to reset values at once.
    msg_sel = 2'd0; pace_div = '0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outs", {out_valid, busy, done, out_data}, 0);
    step();
    rst = 1'b0;
    dn = 0; vc = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      dn += int'(done);
      vc += int'(out_valid) + int'(busy);
    end
    chk("rst_no_done", dn, 0);
    chk("rst_stays_idle", vc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
